// File: rtl/alu_pkg.sv
// Shared Int_ALU definitions: nibble width and the add_sequencer state encoding.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [1:0] add_seq_state_t;

  localparam add_seq_state_t IDLE = 2'd0;
  localparam add_seq_state_t RUN  = 2'd1;
  localparam add_seq_state_t DONE = 2'd2;

endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit ripple adder slice shared by the Int_ALU addition path.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/add_sequencer.sv
// Multi-cycle WIDTH-bit adder that walks one adder_4bit slice across the operand nibbles.
// Define ADD_SEQ_SUB_EN to add the sub port and A-B support.
module add_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  add_seq_state_t   state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [WIDTH-1:0]    b_eff;
  logic                carry_init;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

`ifdef ADD_SEQ_SUB_EN
  // Subtract is A + ~B + 1, so cin is ignored when sub is set.
  assign b_eff      = sub ? ~b : b;
  assign carry_init = sub ? 1'b1 : cin;
`else
  assign b_eff      = b;
  assign carry_init = cin;
`endif

  assign nib_a = a_reg[{idx, 2'b00} +: NIBBLE_W];
  assign nib_b = b_reg[{idx, 2'b00} +: NIBBLE_W];

  adder_4bit u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b_eff;
            carry <= carry_init;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_reg[{idx, 2'b00} +: NIBBLE_W] <= nib_sum;
          carry <= nib_cout;
          if (idx == LAST_IDX) begin
            // Final nibble: its sum MSB is the result sign used for overflow.
            cout_reg <= nib_cout;
            ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (nib_sum[NIBBLE_W-1] != a_reg[WIDTH-1]);
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign overflow  = ovf_reg;

endmodule

// File: tb/tb_add_sequencer.sv
// Directed self-checking bench for add_sequencer at WIDTH = 16.
// Subtract scenarios are exercised when ADD_SEQ_SUB_EN is defined.
module tb_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
`ifdef ADD_SEQ_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  add_sequencer #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADD_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  // Drives one operand pair while idle and waits (bounded) for out_valid; lat counts edges after accept.
  task automatic start_and_wait(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                                input logic sv, output int lat);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
`ifdef ADD_SEQ_SUB_EN
    sub = sv;
`else
    if (sv) $display("[TB] note: sub requested without subtract support");
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input int lat, input logic [15:0] es,
                              input logic ec, input logic eo);
    compared++; if (lat !== 4) begin mismatched++; $display("[TB] FAIL %s latency got %0d want 4", name, lat); end
    compared++; if (sum !== es) begin mismatched++; $display("[TB] FAIL %s sum got %h want %h", name, sum, es); end
    compared++; if (cout !== ec) begin mismatched++; $display("[TB] FAIL %s cout got %b want %b", name, cout, ec); end
    compared++; if (overflow !== eo) begin mismatched++; $display("[TB] FAIL %s overflow got %b want %b", name, overflow, eo); end
    release_result();
    compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL %s post-handshake out_valid/in_ready got %b/%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef ADD_SEQ_SUB_EN
    sub = 1'b0;
`endif
    #12;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset in_ready got %b want 1", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset out_valid got %b want 0", out_valid); end
    compared++; if ({sum, cout, overflow} !== 18'h0) begin
      mismatched++; $display("[TB] FAIL reset sum/cout/ovf got %h/%b/%b want 0000/0/0", sum, cout, overflow);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    start_and_wait(16'h0002, 16'h0003, 1'b0, 1'b0, lat); check_result("add_2_3", lat, 16'h0005, 1'b0, 1'b0);
    start_and_wait(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat); check_result("ripple_ffff", lat, 16'h0000, 1'b1, 1'b0);
    start_and_wait(16'h000F, 16'h0000, 1'b1, 1'b0, lat); check_result("cin_000f", lat, 16'h0010, 1'b0, 1'b0);
    start_and_wait(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat); check_result("ovf_7fff", lat, 16'h8000, 1'b0, 1'b1);
    start_and_wait(16'h8000, 16'h8000, 1'b0, 1'b0, lat); check_result("ovf_8000", lat, 16'h0000, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int lat;
    start_and_wait(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    compared++; if (lat !== 4) begin mismatched++; $display("[TB] FAIL bp latency got %0d want 4", lat); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      compared++; if (sum !== 16'h3333 || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        mismatched++; $display("[TB] FAIL bp_hold%0d sum/cout/ov/ir got %h/%b/%b/%b want 3333/0/1/0", i, sum, cout, out_valid, in_ready);
      end
    end
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    compared++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL bp_handshake in_ready/out_valid got %b/%b want 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_accept in_ready got %b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    check_result("bp_next", lat, 16'h0100, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort();
    int lat;
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    compared++; if (out_valid !== 1'b0 || sum !== 16'h0000 || in_ready !== 1'b1 || cout !== 1'b0) begin
      mismatched++; $display("[TB] FAIL abort ov/sum/ir/cout got %b/%h/%b/%b want 0/0000/1/0", out_valid, sum, in_ready, cout);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL abort_after ov/ir got %b/%b want 0/1", out_valid, in_ready);
    end
    start_and_wait(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
    check_result("after_abort", lat, 16'h2345, 1'b0, 1'b0);
  endtask

`ifdef ADD_SEQ_SUB_EN
  task automatic test_sub();
    int lat;
    start_and_wait(16'h0005, 16'h0007, 1'b0, 1'b1, lat); check_result("sub_5_7", lat, 16'hFFFE, 1'b0, 1'b0);
    start_and_wait(16'h8000, 16'h0001, 1'b0, 1'b1, lat); check_result("sub_8000_1", lat, 16'h7FFF, 1'b1, 1'b1);
    start_and_wait(16'h0007, 16'h0005, 1'b0, 1'b1, lat); check_result("sub_7_5", lat, 16'h0002, 1'b1, 1'b0);
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_reset_abort();
`ifdef ADD_SEQ_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
